// File: rtl/lamp_seq_checker.sv
// rtl/lamp_seq_checker.sv - lamp bus sequence checker with lock FSM and saturating counters
module lamp_seq_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       lamb,
  input  logic             clr,
  output logic             locked,
  output logic [1:0]       mode,
  output logic [3:0]       step,
  output logic             err,
  output logic             cycle_done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    ARM   = 2'd1,
    TRACK = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t     state;
  logic [3:0] exp_idx;
  logic [7:0] exp_pat;
  logic [1:0] exp_mode;
  logic       hit;

  // Pattern expected at the current index; lamb[7] is the leftmost lamp
  always_comb begin
    exp_pat = 8'h00;
    case (exp_idx)
      4'd0:    exp_pat = 8'h00;
      4'd1:    exp_pat = 8'hFF;
      4'd2:    exp_pat = 8'h80;
      4'd3:    exp_pat = 8'h40;
      4'd4:    exp_pat = 8'h20;
      4'd5:    exp_pat = 8'h10;
      4'd6:    exp_pat = 8'h08;
      4'd7:    exp_pat = 8'h04;
      4'd8:    exp_pat = 8'h02;
      4'd9:    exp_pat = 8'h01;
      4'd10:   exp_pat = 8'h55;
      4'd11:   exp_pat = 8'hAA;
      default: exp_pat = 8'h00;
    endcase
  end

  // Phase reported when the current index is matched: blank/full, walking bit, checkerboard
  always_comb begin
    exp_mode = 2'd2;
    if (exp_idx <= 4'd1) begin
      exp_mode = 2'd1;
    end else if (exp_idx >= 4'd10) begin
      exp_mode = 2'd3;
    end
  end

  // Sample comparison against the tracked pattern
  always_comb begin
    hit = (lamb == exp_pat);
  end

  // Lock FSM with registered outputs; clr is applied last so it wins over any increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      exp_idx    <= 4'd0;
      locked     <= 1'b0;
      mode       <= 2'd0;
      step       <= 4'd0;
      err        <= 1'b0;
      cycle_done <= 1'b0;
      cycle_cnt  <= '0;
      err_cnt    <= '0;
    end else begin
      err        <= 1'b0;
      cycle_done <= 1'b0;
      case (state)
        HUNT: begin
          locked <= 1'b0;
          mode   <= 2'd0;
          step   <= 4'd0;
          if (lamb == 8'h00) begin
            state <= ARM;
          end
        end
        ARM: begin
          if (lamb == 8'hFF) begin
            state   <= TRACK;
            exp_idx <= 4'd2;
            locked  <= 1'b1;
            mode    <= 2'd1;
            step    <= 4'd1;
          end else begin
            locked <= 1'b0;
            mode   <= 2'd0;
            step   <= 4'd0;
            if (lamb != 8'h00) begin
              state <= HUNT;
            end
          end
        end
        TRACK: begin
          if (hit) begin
            locked <= 1'b1;
            step   <= exp_idx;
            mode   <= exp_mode;
            if (exp_idx == 4'd11) begin
              exp_idx    <= 4'd0;
              cycle_done <= 1'b1;
              if (cycle_cnt != CNT_MAX) begin
                cycle_cnt <= cycle_cnt + CNT_ONE;
              end
            end else begin
              exp_idx <= exp_idx + 4'd1;
            end
          end else begin
            err     <= 1'b1;
            locked  <= 1'b0;
            mode    <= 2'd0;
            step    <= 4'd0;
            exp_idx <= 4'd0;
            state   <= (lamb == 8'h00) ? ARM : HUNT;
            if (err_cnt != CNT_MAX) begin
              err_cnt <= err_cnt + CNT_ONE;
            end
          end
        end
        default: begin
          state   <= HUNT;
          exp_idx <= 4'd0;
          locked  <= 1'b0;
          mode    <= 2'd0;
          step    <= 4'd0;
        end
      endcase
      if (clr) begin
        cycle_cnt <= '0;
        err_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lamp_seq_checker.sv
// tb/tb_lamp_seq_checker.sv - table-driven bench for lamp_seq_checker
module tb_lamp_seq_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] lamb;
  logic       clr;
  logic       locked;
  logic [1:0] mode;
  logic [3:0] step;
  logic       err;
  logic       cycle_done;
  logic [7:0] cycle_cnt;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] lamb;
    logic       clr;
    logic       locked;
    logic [1:0] mode;
    logic [3:0] step;
    logic       err;
    logic       cd;
    int         cc;
    int         ec;
  } vec_t;

  vec_t vecs[$];

  logic [7:0] pat_tab  [12] = '{8'h00, 8'hFF, 8'h80, 8'h40, 8'h20, 8'h10,
                                8'h08, 8'h04, 8'h02, 8'h01, 8'h55, 8'hAA};
  int         mode_tab [12] = '{1, 1, 2, 2, 2, 2, 2, 2, 2, 2, 3, 3};

  lamp_seq_checker #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lamb       (lamb),
    .clr        (clr),
    .locked     (locked),
    .mode       (mode),
    .step       (step),
    .err        (err),
    .cycle_done (cycle_done),
    .cycle_cnt  (cycle_cnt),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] l, input logic c, input logic lk,
                              input int md, input int st, input logic e,
                              input logic cd, input int cc, input int ec);
    vec_t v;
    v.lamb = l; v.clr = c; v.locked = lk; v.mode = md[1:0]; v.step = st[3:0];
    v.err = e; v.cd = cd; v.cc = cc; v.ec = ec;
    return v;
  endfunction

  task automatic check_outs(input string nm, input vec_t v);
    chk({nm, " locked"}, int'(locked), int'(v.locked));
    chk({nm, " mode"}, int'(mode), int'(v.mode));
    chk({nm, " step"}, int'(step), int'(v.step));
    chk({nm, " err"}, int'(err), int'(v.err));
    chk({nm, " cycle_done"}, int'(cycle_done), int'(v.cd));
    chk({nm, " cycle_cnt"}, int'(cycle_cnt), v.cc);
    chk({nm, " err_cnt"}, int'(err_cnt), v.ec);
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    @(negedge clk);
    lamb = v.lamb;
    clr  = v.clr;
    @(posedge clk);
    #1;
    check_outs(nm, v);
    clr = 1'b0;
  endtask

  task automatic drive(input logic [7:0] l, input logic c);
    @(negedge clk);
    lamb = l;
    clr  = c;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    lamb  = 8'h00;
    clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", mk(8'h00, 1'b0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    // Three full cycles: first 0x00 arms, first 0xFF locks, step follows the index
    for (int i = 0; i < 36; i++) begin
      int idx;
      idx = i % 12;
      if (i == 0) vecs.push_back(mk(pat_tab[0], 0, 0, 0, 0, 0, 0, 0, 0));
      else vecs.push_back(mk(pat_tab[idx], 0, 1, mode_tab[idx], idx, 0,
                             idx == 11, (i + 1) / 12, 0));
    end
    // Mismatch on 0x21 after 0x80, 0x40, then relock
    vecs.push_back(mk(8'h00, 0, 1, 1, 0, 0, 0, 3, 0));
    vecs.push_back(mk(8'hFF, 0, 1, 1, 1, 0, 0, 3, 0));
    vecs.push_back(mk(8'h80, 0, 1, 2, 2, 0, 0, 3, 0));
    vecs.push_back(mk(8'h40, 0, 1, 2, 3, 0, 0, 3, 0));
    vecs.push_back(mk(8'h21, 0, 0, 0, 0, 1, 0, 3, 1));
    vecs.push_back(mk(8'h00, 0, 0, 0, 0, 0, 0, 3, 1));
    vecs.push_back(mk(8'hFF, 0, 1, 1, 1, 0, 0, 3, 1));
    // Mismatch of 0x00 at exp=5 goes straight to ARM; 0xFF relocks
    vecs.push_back(mk(8'h80, 0, 1, 2, 2, 0, 0, 3, 1));
    vecs.push_back(mk(8'h40, 0, 1, 2, 3, 0, 0, 3, 1));
    vecs.push_back(mk(8'h20, 0, 1, 2, 4, 0, 0, 3, 1));
    vecs.push_back(mk(8'h00, 0, 0, 0, 0, 1, 0, 3, 2));
    vecs.push_back(mk(8'hFF, 0, 1, 1, 1, 0, 0, 3, 2));
    // Drop to HUNT, then repeated 0x00 holds ARM with no err until 0xFF
    vecs.push_back(mk(8'h33, 0, 0, 0, 0, 1, 0, 3, 3));
    vecs.push_back(mk(8'h00, 0, 0, 0, 0, 0, 0, 3, 3));
    vecs.push_back(mk(8'h00, 0, 0, 0, 0, 0, 0, 3, 3));
    vecs.push_back(mk(8'h00, 0, 0, 0, 0, 0, 0, 3, 3));
    vecs.push_back(mk(8'hFF, 0, 1, 1, 1, 0, 0, 3, 3));

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // 260 forced mismatches from TRACK: err_cnt saturates, err keeps pulsing
    for (int k = 0; k < 260; k++) begin
      drive(8'h33, 1'b0);
      if (k == 0 || k == 259) chk($sformatf("sat err k%0d", k), int'(err), 1);
      drive(8'h00, 1'b0);
      drive(8'hFF, 1'b0);
    end
    chk("sat err_cnt", int'(err_cnt), 255);
    chk("sat locked", int'(locked), 1);
    // clr together with a mismatch: err still pulses, both counters cleared
    run_vec("clr+mismatch", mk(8'h33, 1, 0, 0, 0, 1, 0, 0, 0));

    // One full cycle then advance to step=7
    for (int i = 0; i < 12; i++) drive(pat_tab[i], 1'b0);
    chk("pre-rst cycle_cnt", int'(cycle_cnt), 1);
    for (int i = 0; i < 8; i++) drive(pat_tab[i], 1'b0);
    chk("pre-rst step", int'(step), 7);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async rst", mk(8'h00, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    chk("rst held err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("post-rst 00", mk(8'h00, 0, 0, 0, 0, 0, 0, 0, 0));
    run_vec("post-rst FF", mk(8'hFF, 0, 1, 1, 1, 0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lamp_seq_checker.md
LAMP_SEQ_CHECKER -- requirements
Module: lamp_seq_checker

Interface
REQ-001 Parameter: CNT_W, default 8, width of both saturating counters.
REQ-002 Port: clk  input  1  rising-edge clock; the only clock.
REQ-003 Port: rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 Port: lamb  input  8  lamp bus under check; sampled every rising edge of clk.
REQ-005 Port: clr  input  1  synchronous clear of both counters; active-high.
REQ-006 Port: locked  output  1  high while tracking the sequence.
REQ-007 Port: mode  output  2  phase of the last matched pattern; 0 when unlocked.
REQ-008 Port: step  output  4  index (0-11) of the last matched pattern; 0 when unlocked.
REQ-009 Port: err  output  1  one-cycle pulse on a mismatch while locked.
REQ-010 Port: cycle_done  output  1  one-cycle pulse when index 11 is matched.
REQ-011 Port: cycle_cnt  output  CNT_W  count of completed cycles; saturates at all-ones.
REQ-012 Port: err_cnt  output  CNT_W  count of mismatches; saturates at all-ones.

Function
REQ-013 Expected sequence, index 0..11, one sample per clock:
- 0x00, 0xFF, 0x80, 0x40, 0x20, 0x10, 0x08, 0x04, 0x02, 0x01, 0x55, 0xAA.
- After index 11, the sequence wraps to index 0.
REQ-014 All outputs shall be registered and update on the same edge that samples lamb; there is no additional latency.
REQ-015 FSM states: HUNT (unlocked), ARM (0x00 seen in HUNT), TRACK (locked, with expected index exp).
REQ-016 HUNT:
- lamb==0x00 -> ARM.
- Any other value -> stay in HUNT.
REQ-017 ARM:
- lamb==0xFF -> TRACK, exp=2, locked=1, step=1, mode=1.
- lamb==0x00 -> stay in ARM.
- Any other value -> HUNT.
- No err is raised in ARM.
REQ-018 TRACK, when lamb equals pattern[exp]:
- step=exp.
- exp advances modulo 12.
REQ-019 TRACK, when lamb differs from pattern[exp]:
- err=1 for one cycle.
- err_cnt increments.
- locked=0, mode=0, step=0.
- Next state is ARM if lamb==0x00, otherwise HUNT.
REQ-020 mode encoding for the matched index:
- 0-1 -> 1.
- 2-9 -> 2.
- 10-11 -> 3.
REQ-021 Matching index 11 in TRACK shall pulse cycle_done and increment cycle_cnt.
REQ-022 Counter saturation: at all-ones a counter shall hold its value, and err/cycle_done shall still pulse.
REQ-023 clr=1 shall zero both counters on that edge, overriding any same-cycle increment; the FSM and all other outputs shall be unaffected.
REQ-024 Outputs in HUNT/ARM: locked=0, mode=0, step=0.
REQ-025 Bit ordering: lamb[7] is the leftmost lamp; pattern index 2 (0x80) has only bit 7 set.

Reset
REQ-026 While rst_n=0, the block shall be asynchronously forced to:
- state=HUNT, exp=0.
- locked=0, mode=0, step=0, err=0, cycle_done=0, cycle_cnt=0, err_cnt=0.
REQ-027 rst_n asserted mid-TRACK shall abort tracking immediately, with no err pulse.
REQ-028 After rst_n deassertion, the first sampling edge shall be evaluated in HUNT.

Verification
REQ-029 Bench shall drive the 12-pattern sequence 3 times after reset and check:
- locked rises on the edge sampling the first 0xFF.
- step follows 1,2,...,11,0,...
- cycle_done pulses 3 times.
- cycle_cnt=3, err_cnt=0.
REQ-030 Bench shall drive lock, then 0x80, 0x40, 0x21 and check:
- err pulses on the edge sampling 0x21.
- locked=0 on that edge.
- err_cnt=1.
- The following 0x00, 0xFF re-locks.
REQ-031 Bench shall drive a mismatch value of 0x00 at exp=5, then 0xFF and check:
- err pulses.
- The FSM enters ARM.
- The next edge sets locked=1, step=1.
REQ-032 Bench shall drive 0x00, 0x00, 0x00, 0xFF and check:
- ARM is held through the repeated 0x00 samples.
- Lock occurs on the 0xFF sample.
- err is never raised.
REQ-033 Bench shall drive 260 forced mismatches (with CNT_W=8) and check:
- err_cnt saturates at 255.
- clr asserted in the same cycle as a mismatch yields err_cnt=0 with err=1.
REQ-034 Bench shall assert rst_n=0 asynchronously at step=7 and check:
- All outputs clear before the next edge.
- After release, 0x00, 0xFF re-locks with cycle_cnt=0.
